// File: rtl/parser_stage_scheduler_if.sv
// Ingress stream handshake bundle for the parser stage scheduler.
// The master drives the beat and downstream ready; the scheduler (slave) returns s_tready.
interface parser_stage_scheduler_if;
  logic s_tvalid;
  logic s_tready;
  logic s_tuser;
  logic s_tlast;
  logic m_tready;

  modport master (output s_tvalid, s_tuser, s_tlast, m_tready, input s_tready);
  modport slave  (input s_tvalid, s_tuser, s_tlast, m_tready, output s_tready);
endinterface

// File: rtl/parser_stage_scheduler.sv
// Header-parse sequencer: one-hot stage strobes per header beat, payload flag, runt detection.
// Optional statistics counters are built only when PARSER_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a start-of-packet beat (s_tuser)
// HDR     | loading header stages 1..NUM_STAGES-1, idx = stage owning the next beat
// PAYLOAD | header complete, flagging payload beats until s_tlast
module parser_stage_scheduler #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  parser_stage_scheduler_if.slave axis,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  payload_en,
  output logic                  hdr_done,
  output logic                  runt_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      runt_count
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             accept;

  assign axis.s_tready = axis.m_tready & ~rst;
  assign accept        = axis.s_tvalid & axis.s_tready;
  assign busy          = ~rst & (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    stage_en   = '0;
    payload_en = 1'b0;
    hdr_done   = 1'b0;
    runt_err   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (axis.s_tuser) begin
            stage_en[0] = 1'b1;
            if (NUM_STAGES == 1) begin
              hdr_done  = 1'b1;
              state_nxt = axis.s_tlast ? IDLE : PAYLOAD;
            end else if (axis.s_tlast) begin
              runt_err = 1'b1;
            end else begin
              state_nxt = HDR;
              idx_nxt   = IDX_W'(1);
            end
          end
        end
        HDR: begin
          stage_en[idx] = 1'b1;
          if (idx == LAST_IDX) begin
            hdr_done  = 1'b1;
            idx_nxt   = '0;
            state_nxt = axis.s_tlast ? IDLE : PAYLOAD;
          end else if (axis.s_tlast) begin
            runt_err  = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
        PAYLOAD: begin
          payload_en = 1'b1;
          if (axis.s_tlast) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

`ifdef PARSER_STATS_EN
  // Saturating counters: a stuck-at-max count is more useful than a wrapped one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      runt_count <= '0;
    end else begin
      if (hdr_done && (pkt_count != '1))  pkt_count  <= pkt_count + CNT_W'(1);
      if (runt_err && (runt_count != '1)) runt_count <= runt_count + CNT_W'(1);
    end
  end
`else
  assign pkt_count  = '0;
  assign runt_count = '0;
`endif

endmodule
